// File: rtl/task_fifo_mq_if.sv
// Handshake bundle for task_fifo_mq: tagged write port plus registered valid/ready output.
// master = dispatcher/consumer side, slave = the buffer.
interface task_fifo_mq_if #(
    parameter int PTW           = 16,
    parameter int MTW           = 16,
    parameter int TREE_NUM      = 4,
    parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
    parameter int EW            = PTW + MTW + 1
);
    logic                     wr_en;
    logic [TREE_NUM_BITS-1:0] wr_tree;
    logic [EW-1:0]            wr_data;
    logic                     wr_drop;

    logic                     out_valid;
    logic                     out_ready;
    logic [TREE_NUM_BITS-1:0] out_tree;
    logic [EW-1:0]            out_data;

    modport master (
        output wr_en, wr_tree, wr_data, out_ready,
        input  wr_drop, out_valid, out_tree, out_data
    );

    modport slave (
        input  wr_en, wr_tree, wr_data, out_ready,
        output wr_drop, out_valid, out_tree, out_data
    );
endinterface

// File: rtl/task_fifo_mq.sv
// Multi-queue task buffer: TREE_NUM FIFOs in one partitioned array, round-robin drained to a registered output.
// Optional macro TASK_FIFO_DROP_CNT_EN builds a saturating dropped-write counter on drop_cnt.
module task_fifo_mq #(
    parameter int PTW           = 16,
    parameter int MTW           = 16,
    parameter int TREE_NUM      = 4,
    parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
    parameter int DEPTH         = 8,
    parameter int AFULL_TH      = 6,
    parameter int EW            = PTW + MTW + 1,
    parameter int CW            = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    task_fifo_mq_if.slave          bus,
    output logic [TREE_NUM*CW-1:0] ch_count,
    output logic [TREE_NUM-1:0]    ch_empty,
    output logic [TREE_NUM-1:0]    ch_afull,
    output logic [15:0]            drop_cnt
);
    localparam int PW    = $clog2(DEPTH);
    localparam int AW    = TREE_NUM_BITS + PW;
    localparam int SLOTS = TREE_NUM * DEPTH;

    logic [EW-1:0]            mem    [SLOTS];
    logic [CW-1:0]            cnt    [TREE_NUM];
    logic [PW-1:0]            rd_ptr [TREE_NUM];
    logic [PW-1:0]            wr_ptr [TREE_NUM];
    logic [TREE_NUM_BITS-1:0] rr_ptr;

    logic                     load;
    logic                     grant_valid;
    logic [TREE_NUM_BITS-1:0] grant_idx;
    logic [TREE_NUM_BITS-1:0] sel;
    logic                     grant_fire;
    logic                     wr_full;
    logic                     wr_accept;
    logic [AW-1:0]            wr_addr;
    logic [AW-1:0]            rd_addr;
    logic [EW-1:0]            head;
    logic [TREE_NUM-1:0]      wr_hit;
    logic [TREE_NUM-1:0]      rd_hit;

    assign load = !bus.out_valid || bus.out_ready;

    // Scan from the farthest candidate to the nearest so the nearest non-empty queue after rr_ptr wins.
    // NOTE: every always_comb output gets a default before any conditional assignment, so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sel         = '0;
        for (int off = TREE_NUM; off >= 1; off--) begin
            sel = TREE_NUM_BITS'((int'(rr_ptr) + off) % TREE_NUM);
            if (cnt[sel] != '0) begin
                grant_valid = 1'b1;
                grant_idx   = sel;
            end
        end
    end

    assign grant_fire = load && grant_valid;

    // A full queue still accepts when its head leaves in the same cycle; the slot frees as it refills.
    assign wr_full   = (cnt[bus.wr_tree] == CW'(DEPTH));
    assign wr_accept = bus.wr_en && (!wr_full || (grant_fire && (grant_idx == bus.wr_tree)));
    assign bus.wr_drop = bus.wr_en && !wr_accept;

    // DEPTH is a power of two, so {tree, ptr} is exactly tree*DEPTH + ptr.
    assign wr_addr = {bus.wr_tree, wr_ptr[bus.wr_tree]};
    assign rd_addr = {grant_idx, rd_ptr[grant_idx]};
    assign head    = mem[rd_addr];

    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int i = 0; i < TREE_NUM; i++) begin
            wr_hit[i] = wr_accept  && (bus.wr_tree == TREE_NUM_BITS'(i));
            rd_hit[i] = grant_fire && (grant_idx   == TREE_NUM_BITS'(i));
        end
    end

    // NOTE: storage has no reset; counts and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= bus.wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TREE_NUM; i++) begin
                cnt[i]    <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
            rr_ptr        <= TREE_NUM_BITS'(TREE_NUM - 1);
            bus.out_valid <= 1'b0;
            bus.out_tree  <= '0;
            bus.out_data  <= '0;
        end else begin
            for (int i = 0; i < TREE_NUM; i++) begin
                if (wr_hit[i] && !rd_hit[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!wr_hit[i] && rd_hit[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
                if (wr_hit[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (rd_hit[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end

            if (load) begin
                if (grant_valid) begin
                    bus.out_valid <= 1'b1;
                    bus.out_tree  <= grant_idx;
                    bus.out_data  <= head;
                    rr_ptr        <= grant_idx;
                end else begin
                    bus.out_valid <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < TREE_NUM; g++) begin : g_status
        assign ch_count[g*CW +: CW] = cnt[g];
        assign ch_empty[g]          = (cnt[g] == '0);
        assign ch_afull[g]          = (cnt[g] >= CW'(AFULL_TH));
    end

`ifdef TASK_FIFO_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (bus.wr_drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule
